ctrl_seq: RTL and testbench
===========================

# ctrl_seq

Multi-cycle instruction sequencer for the 9-bit core: fetches from the instruction ROM, decodes the 5-bit opcode, and drives `alu_op`, register selects, immediate, write strobes and the carry feedback into the ALU. It consumes the ALU's `jump` and `ov_o` results to redirect the PC and update the carry flag. It sits between instruction ROM, register file, data memory and ALU, and implements the Start/Ack program handshake.

## Interface
- `PC_W`, default 10: program counter width; ROM depth is 2^PC_W.
- `CLK` input 1: single clock, rising edge.
- `Reset` input 1: asynchronous, active-high; forces IDLE and all outputs to reset values.
- `start_i` input 1: program start request, sampled only in IDLE or HALTED.
- `inst_i` input 9: ROM data at `pc_o`, combinational read.
- `alu_jump_i` input 1: ALU branch-taken result.
- `alu_ov_i` input 1: ALU carry/borrow out.
- `pc_o` output PC_W: ROM address; reset 0.
- `alu_op_o` output 5: opcode of the current instruction register (IR); reset 0.
- `rs_o` / `rt_o` output 2 each: IR[3:2] / IR[1:0]; reset 0.
- `imm_o` output 8: extension word [7:0]; reset 0.
- `ov_o` output 1: carry flag register to ALU `ov_i`; reset 0.
- `reg_we_o`, `mem_we_o`, `mem_re_o` output 1 each: one-cycle strobes; reset 0.
- `ack_o` output 1: program finished; reset 0.
- `inst_cnt_o` output 16: retired-instruction count (see Configuration); reset 0.

## Operation
- Format: IR[8:4] opcode, IR[3:0] rs/rt. Two-word opcodes (ANDI 01000, ORRI 01010, MOVI 01100, BEQ..BLT 01101–10001) read one extension word: immediate in [7:0], or branch target in [PC_W-1:0] (zero-extended when PC_W > 9).
- Single-word opcodes: 00000–00111, 01001, 01011. HALT = 11111. Opcodes 10010–11110 are NOPs: no strobes, no flag change.
- States: IDLE, FETCH, EXT, EXEC, MEM, HALTED.
- IDLE/HALTED with `start_i`=1 → FETCH; `pc_o`←0, `ov_o`←0, `ack_o`←0. `start_i` is ignored in all other states.
- FETCH: IR←`inst_i`, `pc_o`←`pc_o`+1. Next is EXT for two-word opcodes, otherwise EXEC.
- EXT: extension register ← `inst_i`, `pc_o`←`pc_o`+1, → EXEC.
- EXEC strobes, one cycle:
  - ALU/immediate ops: `reg_we_o`.
  - STR: `mem_we_o`.
  - LDR: `mem_re_o`, then → MEM.
  - Branches: no strobe; if `alu_jump_i` then `pc_o`←target.
  - ADD/SUB: `ov_o`←`alu_ov_i`. No other opcode changes `ov_o`.
  - HALT: → HALTED.
  - All others: → FETCH.
- MEM: `reg_we_o` asserted (1-cycle data memory latency), → FETCH.
- HALTED: `ack_o`=1 held until restart or Reset.

## Timing
- Cycles per instruction:
  - Single-word ALU ops, STR, NOP: 2 (FETCH, EXEC).
  - Immediate ops and branches: 3.
  - LDR: 3 (FETCH, EXEC, MEM).
  - HALT: 2, then `ack_o` rises on the next edge.
- `alu_op_o`, `rs_o`, `rt_o` and `imm_o` are registered. They are stable from the cycle after they load through EXEC, so the ALU is combinationally settled within EXEC. Strobes are asserted only in EXEC or MEM.
- `alu_jump_i` and `alu_ov_i` are sampled only on the EXEC edge.
- PC arithmetic is modulo 2^PC_W; fetch at address 2^PC_W−1 wraps to 0.
- A branch whose extension word sits at the last address still uses its own target.
- Reset asserted in any state returns all outputs to reset values within the same cycle (async). The first FETCH after Reset requires `start_i`.
- `start_i` held high in HALTED restarts immediately: `ack_o` is high for exactly one cycle.

## Configuration
- `CTRL_PERF_CNT_EN` defined: `inst_cnt_o` increments by 1 at each instruction retirement (EXEC edge, or MEM edge for LDR; HALT counts). It clears on Reset and on Start, and saturates at 16'hFFFF.
- Not defined: no counter logic is built and `inst_cnt_o` is tied to 0.

## Test plan
- Reset mid-EXT of MOVI: all outputs are 0 and state is IDLE. Then pulse `start_i` with ROM[0]=ADD → `pc_o`=1 after FETCH, `reg_we_o` high for exactly one cycle two cycles after start.
- MOVI extension 8'hA5 at ROM[1]: `imm_o`=8'hA5 and `alu_op_o`=5'b01100 in EXEC, `reg_we_o` in cycle 3, `pc_o`=2.
- BEQ at ROM[4] with target 9'h012:
  - `alu_jump_i`=1 → `pc_o`=0x012 after EXEC.
  - `alu_jump_i`=0 → `pc_o`=6.
- ADD with `alu_ov_i`=1, then MOV with `alu_ov_i`=0: `ov_o` stays 1. A following SUB with `alu_ov_i`=0 clears `ov_o`.
- LDR: `mem_re_o` in EXEC, `reg_we_o` in MEM; the next FETCH occurs 3 cycles after the prior FETCH.
- HALT at ROM[3FF] (PC_W=10) after the PC wraps from 3FF to 0 once:
  - `ack_o` goes high and stays high.
  - `start_i` restarts at pc 0.
  - With `CTRL_PERF_CNT_EN`, `inst_cnt_o` equals the number of retired instructions.

Source files
------------

// File: rtl/ctrl_seq.sv
// Multi-cycle fetch/decode/execute sequencer for the 9-bit core, with Start/Ack handshake.
// Optional retired-instruction counter is built when CTRL_PERF_CNT_EN is defined.
module ctrl_seq #(
    parameter int PC_W = 10
) (
    input  logic            CLK,
    input  logic            Reset,
    input  logic            start_i,
    input  logic [8:0]      inst_i,
    input  logic            alu_jump_i,
    input  logic            alu_ov_i,
    output logic [PC_W-1:0] pc_o,
    output logic [4:0]      alu_op_o,
    output logic [1:0]      rs_o,
    output logic [1:0]      rt_o,
    output logic [7:0]      imm_o,
    output logic            ov_o,
    output logic            reg_we_o,
    output logic            mem_we_o,
    output logic            mem_re_o,
    output logic            ack_o,
    output logic [15:0]     inst_cnt_o
);

    localparam logic [4:0] OP_ADD  = 5'b00000;
    localparam logic [4:0] OP_SUB  = 5'b00001;
    localparam logic [4:0] OP_LDR  = 5'b00110;
    localparam logic [4:0] OP_STR  = 5'b00111;
    localparam logic [4:0] OP_ANDI = 5'b01000;
    localparam logic [4:0] OP_ORRI = 5'b01010;
    localparam logic [4:0] OP_MOVI = 5'b01100;
    localparam logic [4:0] OP_BEQ  = 5'b01101;
    localparam logic [4:0] OP_BLT  = 5'b10001;
    localparam logic [4:0] OP_HALT = 5'b11111;

    typedef enum logic [2:0] {IDLE, FETCH, EXT, EXEC, MEM, HALTED} state_t;

    state_t     state;
    logic [8:0] ext_q;

    function automatic logic is_two_word(input logic [4:0] op);
        return (op == OP_ANDI) || (op == OP_ORRI) || (op >= OP_MOVI && op <= OP_BLT);
    endfunction

    function automatic logic is_branch(input logic [4:0] op);
        return (op >= OP_BEQ) && (op <= OP_BLT);
    endfunction

    // Every opcode up to MOVI writes the register file, except the memory ops.
    function automatic logic writes_reg(input logic [4:0] op);
        return (op <= OP_MOVI) && (op != OP_LDR) && (op != OP_STR);
    endfunction

    assign imm_o = ext_q[7:0];

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state    <= IDLE;
            pc_o     <= '0;
            alu_op_o <= '0;
            rs_o     <= '0;
            rt_o     <= '0;
            ext_q    <= '0;
            ov_o     <= 1'b0;
            reg_we_o <= 1'b0;
            mem_we_o <= 1'b0;
            mem_re_o <= 1'b0;
            ack_o    <= 1'b0;
        end else begin
            // NOTE: strobes default low here so each one lasts exactly one cycle; non-blocking
            // assignments let later branches override these defaults without ordering hazards.
            reg_we_o <= 1'b0;
            mem_we_o <= 1'b0;
            mem_re_o <= 1'b0;
            unique case (state)
                IDLE, HALTED: begin
                    if (start_i) begin
                        state <= FETCH;
                        pc_o  <= '0;
                        ov_o  <= 1'b0;
                        ack_o <= 1'b0;
                    end
                end
                FETCH: begin
                    {alu_op_o, rs_o, rt_o} <= inst_i;
                    pc_o <= pc_o + PC_W'(1);
                    if (is_two_word(inst_i[8:4])) begin
                        state <= EXT;
                    end else begin
                        state    <= EXEC;
                        reg_we_o <= writes_reg(inst_i[8:4]);
                        mem_we_o <= (inst_i[8:4] == OP_STR);
                        mem_re_o <= (inst_i[8:4] == OP_LDR);
                    end
                end
                EXT: begin
                    ext_q    <= inst_i;
                    pc_o     <= pc_o + PC_W'(1);
                    state    <= EXEC;
                    reg_we_o <= writes_reg(alu_op_o);
                end
                EXEC: begin
                    if (is_branch(alu_op_o) && alu_jump_i)
                        pc_o <= PC_W'(ext_q);
                    if (alu_op_o == OP_ADD || alu_op_o == OP_SUB)
                        ov_o <= alu_ov_i;
                    if (alu_op_o == OP_LDR) begin
                        state    <= MEM;
                        reg_we_o <= 1'b1;
                    end else if (alu_op_o == OP_HALT) begin
                        state <= HALTED;
                        ack_o <= 1'b1;
                    end else begin
                        state <= FETCH;
                    end
                end
                MEM: state <= FETCH;
                default: state <= IDLE;
            endcase
        end
    end

`ifdef CTRL_PERF_CNT_EN
    logic retire;
    logic clear;

    assign retire = (state == EXEC && alu_op_o != OP_LDR) || (state == MEM);
    assign clear  = (state == IDLE || state == HALTED) && start_i;

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset)
            inst_cnt_o <= '0;
        else if (clear)
            inst_cnt_o <= '0;
        else if (retire && inst_cnt_o != 16'hFFFF)
            inst_cnt_o <= inst_cnt_o + 16'd1;
    end
`else
    assign inst_cnt_o = '0;
`endif

endmodule

// File: tb/tb_ctrl_seq.sv
// Directed self-checking bench for ctrl_seq: reset, immediates, branches, carry flag,
// loads/stores, PC wrap, HALT/ack handshake and the optional instruction counter.
module tb_ctrl_seq;

    localparam logic [4:0] ADD  = 5'b00000;
    localparam logic [4:0] SUB  = 5'b00001;
    localparam logic [4:0] MOV  = 5'b00101;
    localparam logic [4:0] LDR  = 5'b00110;
    localparam logic [4:0] STR  = 5'b00111;
    localparam logic [4:0] MOVI = 5'b01100;
    localparam logic [4:0] BEQ  = 5'b01101;
    localparam logic [4:0] NOP  = 5'b10010;
    localparam logic [4:0] HALT = 5'b11111;

    logic        CLK = 1'b0;
    logic        Reset;
    logic        start_i;
    logic [8:0]  inst_i;
    logic        alu_jump_i;
    logic        alu_ov_i;
    logic [9:0]  pc_o;
    logic [4:0]  alu_op_o;
    logic [1:0]  rs_o;
    logic [1:0]  rt_o;
    logic [7:0]  imm_o;
    logic        ov_o;
    logic        reg_we_o;
    logic        mem_we_o;
    logic        mem_re_o;
    logic        ack_o;
    logic [15:0] inst_cnt_o;

    logic [8:0] rom [0:1023];
    int checks = 0;
    int errors = 0;

    assign inst_i = rom[pc_o];

    ctrl_seq #(.PC_W(10)) dut (
        .CLK(CLK), .Reset(Reset), .start_i(start_i), .inst_i(inst_i),
        .alu_jump_i(alu_jump_i), .alu_ov_i(alu_ov_i), .pc_o(pc_o),
        .alu_op_o(alu_op_o), .rs_o(rs_o), .rt_o(rt_o), .imm_o(imm_o),
        .ov_o(ov_o), .reg_we_o(reg_we_o), .mem_we_o(mem_we_o),
        .mem_re_o(mem_re_o), .ack_o(ack_o), .inst_cnt_o(inst_cnt_o)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge CLK);
    endtask

    function automatic logic [8:0] word(input logic [4:0] op, input logic [3:0] regs);
        return {op, regs};
    endfunction

    task automatic fill_nop();
        for (int i = 0; i < 1024; i++) rom[i] = word(NOP, 4'h0);
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        tick(1);
        Reset = 1'b0;
    endtask

    // Leaves the bench in the first FETCH cycle with pc 0.
    task automatic start_prog();
        start_i = 1'b1;
        tick(1);
        start_i = 1'b0;
    endtask

    task automatic run_beq(input logic jump, input int exp_pc, input string tag);
        do_reset();
        fill_nop();
        rom[4] = word(BEQ, 4'h0);
        rom[5] = 9'h012;
        start_prog();
        tick(8);
        check({tag, "_fetch_pc"}, 32'(pc_o), 4);
        tick(2);
        check({tag, "_exec_pc"}, 32'(pc_o), 6);
        check({tag, "_no_strobe"}, 32'({reg_we_o, mem_we_o, mem_re_o}), 0);
        alu_jump_i = jump;
        tick(1);
        alu_jump_i = 1'b0;
        check({tag, "_pc_after"}, 32'(pc_o), 32'(exp_pc));
    endtask

    initial begin
        Reset = 1'b1;
        start_i = 1'b0;
        alu_jump_i = 1'b0;
        alu_ov_i = 1'b0;
        fill_nop();
        tick(2);

        // Reset in the middle of a MOVI extension fetch
        rom[0] = word(MOVI, 4'h3);
        rom[1] = 9'h0A5;
        Reset = 1'b0;
        tick(1);
        start_prog();
        tick(1);
        check("movi_ext_pc", 32'(pc_o), 1);
        #2 Reset = 1'b1;
        #1;
        check("async_rst_outs",
              {pc_o, alu_op_o, rs_o, rt_o, imm_o, ov_o, reg_we_o, mem_we_o, mem_re_o, ack_o}, 0);
        check("async_rst_cnt", 32'(inst_cnt_o), 0);
        @(negedge CLK);
        Reset = 1'b0;
        tick(3);
        check("idle_no_start", 32'({pc_o, reg_we_o, alu_op_o}), 0);

        rom[0] = word(ADD, 4'b0110);
        start_prog();
        check("add_fetch_pc", 32'(pc_o), 0);
        tick(1);
        check("add_exec", 32'({pc_o, reg_we_o, alu_op_o, rs_o, rt_o}), {22'd0, 10'd1, 1'b1, 5'd0, 2'd1, 2'd2} >> 0);
        tick(1);
        check("add_we_drop", 32'(reg_we_o), 0);

        // MOVI with extension word A5
        do_reset();
        fill_nop();
        rom[0] = word(MOVI, 4'h3);
        rom[1] = 9'h0A5;
        start_prog();
        tick(1);
        check("movi_ext_no_we", 32'(reg_we_o), 0);
        tick(1);
        check("movi_imm", 32'(imm_o), 'hA5);
        check("movi_op", 32'(alu_op_o), 'h0C);
        check("movi_we_pc", 32'({reg_we_o, pc_o}), {1'b1, 10'd2});
        tick(1);
        check("movi_we_drop", 32'(reg_we_o), 0);

        // Branches, taken and not taken
        run_beq(1'b1, 'h012, "beq_taken");
        run_beq(1'b0, 6, "beq_not_taken");

        // Carry flag only follows ADD/SUB
        do_reset();
        fill_nop();
        rom[0] = word(ADD, 4'h1);
        rom[1] = word(MOV, 4'h2);
        rom[2] = word(SUB, 4'h3);
        start_prog();
        tick(1);
        alu_ov_i = 1'b1;
        tick(1);
        alu_ov_i = 1'b0;
        check("ov_after_add", 32'(ov_o), 1);
        tick(2);
        check("ov_after_mov", 32'(ov_o), 1);
        tick(2);
        check("ov_after_sub", 32'(ov_o), 0);
        alu_ov_i = 1'b1;
        tick(1);
        check("nop_no_strobe", 32'({reg_we_o, mem_we_o, mem_re_o}), 0);
        tick(1);
        alu_ov_i = 1'b0;
        check("ov_after_nop", 32'(ov_o), 0);

        // LDR then STR
        do_reset();
        fill_nop();
        rom[0] = word(LDR, 4'h1);
        rom[1] = word(STR, 4'h2);
        start_prog();
        tick(1);
        check("ldr_exec", 32'({mem_re_o, reg_we_o, mem_we_o}), 3'b100);
        tick(1);
        check("ldr_mem", 32'({mem_re_o, reg_we_o, mem_we_o}), 3'b010);
        tick(1);
        check("ldr_next_fetch", 32'({reg_we_o, pc_o}), 1);
        tick(1);
        check("str_exec", 32'({mem_re_o, reg_we_o, mem_we_o, pc_o}), {3'b001, 10'd2});

        // Branch whose extension word sits at the last address
        do_reset();
        fill_nop();
        rom[1022] = word(BEQ, 4'h0);
        rom[1023] = 9'h012;
        start_prog();
        tick(2044);
        check("last_beq_fetch_pc", 32'(pc_o), 'h3FE);
        tick(1);
        check("last_beq_ext_pc", 32'(pc_o), 'h3FF);
        tick(1);
        check("last_beq_wrap_pc", 32'(pc_o), 0);
        alu_jump_i = 1'b1;
        tick(1);
        alu_jump_i = 1'b0;
        check("last_beq_target", 32'(pc_o), 'h012);

        // Wrap once, then HALT at 3FF
        do_reset();
        fill_nop();
        rom[1022] = word(BEQ, 4'h0);
        rom[1023] = 9'h012;
        start_prog();
        tick(2046);
        check("wrap_pc", 32'(pc_o), 0);
        tick(1);
        rom[1022] = word(NOP, 4'h0);
        rom[1023] = word(HALT, 4'h0);
        tick(2046);
        check("halt_fetch_pc", 32'(pc_o), 'h3FF);
        tick(1);
        check("halt_exec", 32'({ack_o, pc_o}), 0);
        tick(1);
        check("ack_rise", 32'(ack_o), 1);
        tick(3);
        check("ack_hold", 32'(ack_o), 1);
`ifdef CTRL_PERF_CNT_EN
        check("retired_cnt", 32'(inst_cnt_o), 2047);
`else
        check("cnt_tied_zero", 32'(inst_cnt_o), 0);
`endif
        start_prog();
        check("restart", 32'({ack_o, pc_o, inst_cnt_o}), 0);
        tick(2);
`ifdef CTRL_PERF_CNT_EN
        check("cnt_after_restart", 32'({pc_o, inst_cnt_o}), {10'd1, 16'd1});
`else
        check("pc_after_restart", 32'({pc_o, inst_cnt_o}), {10'd1, 16'd0});
`endif

        // start held through HALT: ack lasts one cycle
        do_reset();
        fill_nop();
        rom[0] = word(HALT, 4'h0);
        start_i = 1'b1;
        tick(2);
        check("start_ignored_exec", 32'({pc_o, ack_o}), {10'd1, 1'b0});
        tick(1);
        check("held_ack_high", 32'(ack_o), 1);
        tick(1);
        check("held_ack_low", 32'({ack_o, pc_o}), 0);
        start_i = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
